// File: rtl/dm_arb_pkg.sv
// Shared types and default sizes for the dat_mem arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm_arb_pkg;
    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 8;
    localparam int LOCK_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;
endpackage

// File: rtl/dm_arbiter_if.sv
// Bundles both requester ports and the dat_mem port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are single-cycle; a request without rN_gnt is simply not issued.
// Ports: master = requesters + memory model side, slave = arbiter side.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          r0_req;
    logic          r0_wen;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdat;
    logic          r0_lock;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdat;

    logic          r1_req;
    logic          r1_wen;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdat;
    logic          r1_lock;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdat;

    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          busy;

    modport master (
        output r0_req, r0_wen, r0_addr, r0_wdat, r0_lock,
        input  r0_gnt, r0_rvalid, r0_rdat,
        output r1_req, r1_wen, r1_addr, r1_wdat, r1_lock,
        input  r1_gnt, r1_rvalid, r1_rdat,
        input  mem_wen, mem_addr, mem_din, busy,
        output mem_dout
    );

    modport slave (
        input  r0_req, r0_wen, r0_addr, r0_wdat, r0_lock,
        output r0_gnt, r0_rvalid, r0_rdat,
        input  r1_req, r1_wen, r1_addr, r1_wdat, r1_lock,
        output r1_gnt, r1_rvalid, r1_rdat,
        output mem_wen, mem_addr, mem_din, busy,
        input  mem_dout
    );
endinterface

// File: rtl/rr_pick.sv
// Two-way tie breaker: one-hot winner from req[1:0], round-robin on 'last' or fixed r0 priority.
// Latency: combinational.
// Backpressure: none; an empty request vector yields no winner.
// Ports: req (requests), last (previous winner index), win (one-hot winner).
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (r0 always wins a tie).
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'b00;
        if (req[0])      win = 2'b01;
        else if (req[1]) win = 2'b10;
    end
`else
    always_comb begin
        win = req;
        // On a tie the requester that did not win last time goes next.
        if (req == 2'b11) win = last ? 2'b01 : 2'b10;
    end
`endif
endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates core (r0) and loader (r1) single-cycle accesses onto dat_mem, with bounded lock bursts.
// Latency: grant and memory drive are combinational; read data returns registered, 1 cycle later.
// Backpressure: an ungranted request is dropped for that cycle; the requester re-presents it.
// Ports: clk, start (async active-high reset), bus (dm_arbiter_if.slave: requests, grants,
//        read return, dat_mem port, busy).
// Build option: ARB_FIXED_PRIO_EN (see rr_pick) makes r0 win every idle tie.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic         clk,
    input  logic         start,
    dm_arbiter_if.slave  bus
);
    localparam logic [7:0] LOCK_CAP = 8'(LOCK_MAX);

    arb_state_e    state_q, state_d;
    logic [7:0]    lock_cnt_q, lock_cnt_d;
    logic          last_q, last_d;
    logic [1:0]    req, win, gnt;
    logic [7:0]    cnt_inc;
    logic          lock_sel;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdat0_q, rdat1_q;

    assign req = {bus.r1_req, bus.r0_req};

    rr_pick u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        last_d     = last_q;
        gnt        = 2'b00;
        cnt_inc    = lock_cnt_q + 8'd1;

        unique case (state_q)
            IDLE:    gnt = win;
            OWN0:    gnt = {1'b0, req[0]};
            OWN1:    gnt = {req[1], 1'b0};
            default: gnt = 2'b00;
        endcase
        if (start) gnt = 2'b00;

        lock_sel = gnt[0] ? bus.r0_lock : bus.r1_lock;

        // Any cycle without a grant, or a grant that releases the lock, lands in IDLE
        // with the counter cleared; lock_cnt is therefore always 0 while in IDLE.
        if (gnt != 2'b00) begin
            last_d = gnt[1];
            if (lock_sel && (cnt_inc != LOCK_CAP)) begin
                state_d    = gnt[1] ? OWN1 : OWN0;
                lock_cnt_d = cnt_inc;
            end else begin
                // Either an unlocked access or the lock quota is used up; last_d
                // already marks this requester so the other one wins the next tie.
                state_d    = IDLE;
                lock_cnt_d = 8'd0;
            end
        end else begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
        end
    end

    always_comb begin
        bus.mem_wen  = 1'b0;
        bus.mem_addr = {AW{1'b0}};
        bus.mem_din  = {DW{1'b0}};
        if (gnt[0]) begin
            bus.mem_wen  = bus.r0_wen;
            bus.mem_addr = bus.r0_addr;
            bus.mem_din  = bus.r0_wdat;
        end else if (gnt[1]) begin
            bus.mem_wen  = bus.r1_wen;
            bus.mem_addr = bus.r1_addr;
            bus.mem_din  = bus.r1_wdat;
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q    <= IDLE;
            lock_cnt_q <= 8'd0;
            last_q     <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdat0_q    <= {DW{1'b0}};
            rdat1_q    <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
            rvalid0_q  <= gnt[0] & ~bus.r0_wen;
            rvalid1_q  <= gnt[1] & ~bus.r1_wen;
            if (gnt[0] & ~bus.r0_wen) rdat0_q <= bus.mem_dout;
            if (gnt[1] & ~bus.r1_wen) rdat1_q <= bus.mem_dout;
        end
    end

    assign bus.r0_gnt    = gnt[0];
    assign bus.r1_gnt    = gnt[1];
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.r0_rdat   = rdat0_q;
    assign bus.r1_rdat   = rdat1_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random traffic,
// all compared against an ownership/quota model of the arbitration rules.
// Honours ARB_FIXED_PRIO_EN the same way the design does.
module tb_dm_arbiter;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 8;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic start;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

    dm_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .start (start),
        .bus   (ifc.slave)
    );

    // dat_mem: combinational read, write on the clock edge.
    logic [DW-1:0] env_mem [256];
    assign ifc.mem_dout = env_mem[ifc.mem_addr];
    always @(posedge clk) if (ifc.mem_wen) env_mem[ifc.mem_addr] <= ifc.mem_din;

    // Reference model: who currently owns the memory (-1 nobody), how many
    // consecutive locked grants the owner has had, who won last.
    logic [DW-1:0] mdl_mem [256];
    int            own, held, lastw;
    logic          exp_rv [2];
    logic [DW-1:0] exp_rd [2];
    logic          exp_busy;
    logic          obs_g0, obs_g1;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        own      = -1;
        held     = 0;
        lastw    = 1;
        exp_rv   = '{1'b0, 1'b0};
        exp_rd   = '{8'h00, 8'h00};
        exp_busy = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_r0_rvalid"}, 32'(ifc.r0_rvalid), 32'(exp_rv[0]));
        chk({tag, "_r0_rdat"},   32'(ifc.r0_rdat),   32'(exp_rd[0]));
        chk({tag, "_r1_rvalid"}, 32'(ifc.r1_rvalid), 32'(exp_rv[1]));
        chk({tag, "_r1_rdat"},   32'(ifc.r1_rdat),   32'(exp_rd[1]));
        chk({tag, "_busy"},      32'(ifc.busy),      32'(exp_busy));
    endtask

    // One clock of stimulus. mid_rst raises start late in the cycle, after the
    // grant has been seen, so the access in flight must be abandoned.
    task automatic step(input string tag,
                        input logic q0, input logic k0, input logic w0,
                        input logic [7:0] a0, input logic [7:0] d0,
                        input logic q1, input logic k1, input logic w1,
                        input logic [7:0] a1, input logic [7:0] d1,
                        input bit mid_rst);
        int g;
        logic k, w;
        logic [7:0] a, d;
        @(negedge clk);
        start = 1'b0;
        ifc.r0_req = q0; ifc.r0_lock = k0; ifc.r0_wen = w0; ifc.r0_addr = a0; ifc.r0_wdat = d0;
        ifc.r1_req = q1; ifc.r1_lock = k1; ifc.r1_wen = w1; ifc.r1_addr = a1; ifc.r1_wdat = d1;
        #1;
        if (own >= 0)     g = ((own == 0) ? q0 : q1) ? own : -1;
        else if (q0 && q1) g = FIXED ? 0 : 1 - lastw;
        else if (q0)       g = 0;
        else if (q1)       g = 1;
        else               g = -1;
        k = (g == 0) ? k0 : k1;
        w = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
        a = (g == 0) ? a0 : (g == 1) ? a1 : 8'h00;
        d = (g == 0) ? d0 : (g == 1) ? d1 : 8'h00;
        chk({tag, "_r0_gnt"},   32'(ifc.r0_gnt),   32'(g == 0));
        chk({tag, "_r1_gnt"},   32'(ifc.r1_gnt),   32'(g == 1));
        chk({tag, "_mem_wen"},  32'(ifc.mem_wen),  32'(w));
        chk({tag, "_mem_addr"}, 32'(ifc.mem_addr), 32'(a));
        chk({tag, "_mem_din"},  32'(ifc.mem_din),  32'(d));
        obs_g0 = ifc.r0_gnt;
        obs_g1 = ifc.r1_gnt;
        if (mid_rst) begin
            #2 start = 1'b1;
            #1;
            mdl_reset();
            chk({tag, "_rst_r0_gnt"},  32'(ifc.r0_gnt),  32'd0);
            chk({tag, "_rst_r1_gnt"},  32'(ifc.r1_gnt),  32'd0);
            chk({tag, "_rst_mem_wen"}, 32'(ifc.mem_wen), 32'd0);
            chk({tag, "_rst_busy"},    32'(ifc.busy),    32'd0);
        end else begin
            exp_rv = '{1'b0, 1'b0};
            if (g >= 0) begin
                lastw = g;
                if (w) mdl_mem[a] = d;
                else begin
                    exp_rv[g] = 1'b1;
                    exp_rd[g] = mdl_mem[a];
                end
                if (k) begin
                    held++;
                    if (held == LOCK_MAX) begin own = -1; held = 0; end
                    else own = g;
                end else begin
                    own = -1; held = 0;
                end
            end else begin
                own = -1; held = 0;
            end
            exp_busy = (own >= 0);
        end
        @(posedge clk);
        #1;
        chk_regs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 1'b1;
        ifc.r0_req = 0; ifc.r0_lock = 0; ifc.r0_wen = 0; ifc.r0_addr = 0; ifc.r0_wdat = 0;
        ifc.r1_req = 0; ifc.r1_lock = 0; ifc.r1_wen = 0; ifc.r1_addr = 0; ifc.r1_wdat = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            env_mem[i] = v;
            mdl_mem[i] = v;
        end
        env_mem[8'h10] = 8'h5A;
        mdl_mem[8'h10] = 8'h5A;
        mdl_reset();

        // Reset held: requests are ignored, everything reads back as reset values.
        repeat (2) @(negedge clk);
        ifc.r0_req = 1'b1; ifc.r0_wen = 1'b1; ifc.r1_req = 1'b1;
        #1;
        chk("rst_r0_gnt",  32'(ifc.r0_gnt),  32'd0);
        chk("rst_r1_gnt",  32'(ifc.r1_gnt),  32'd0);
        chk("rst_mem_wen", 32'(ifc.mem_wen), 32'd0);
        chk_regs("rst");

        // Single read with one-cycle return.
        step("rd", 1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        chk("rd_gnt_now",  32'(obs_g0),        32'd1);
        chk("rd_rvalid",   32'(ifc.r0_rvalid), 32'd1);
        chk("rd_rdat",     32'(ifc.r0_rdat),   32'h5A);
        idle("rd_after");
        chk("rd_rvalid_1shot", 32'(ifc.r0_rvalid), 32'd0);

        // Tie: alternate r0,r1,r0,r1 (all r0 with fixed priority).
        step("pre_tie", 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h40, 8'hA0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("tie", 1, 0, 1, 8'(8'h20 + i), 8'(i), 1, 0, 1, 8'(8'h30 + i), 8'(8'h80 + i), 1'b0);
            chk("tie_r0_pattern", 32'(obs_g0), 32'(FIXED || (i % 2 == 0)));
        end

        // Locked burst of three writes by r1 while r0 waits.
        step("lk1", 0, 0, 1, 8'h50, 8'h01, 1, 1, 1, 8'h60, 8'h11, 1'b0);
        chk("lk1_gnt", 32'(obs_g1), 32'd1);
        chk("lk1_busy", 32'(ifc.busy), 32'd1);
        step("lk2", 1, 0, 1, 8'h50, 8'h02, 1, 1, 1, 8'h61, 8'h12, 1'b0);
        chk("lk2_gnt", 32'(obs_g1), 32'd1);
        chk("lk2_busy", 32'(ifc.busy), 32'd1);
        step("lk3", 1, 0, 1, 8'h50, 8'h03, 1, 0, 1, 8'h62, 8'h13, 1'b0);
        chk("lk3_gnt", 32'(obs_g1), 32'd1);
        chk("lk3_busy", 32'(ifc.busy), 32'd0);
        step("lk4", 1, 0, 1, 8'h50, 8'h04, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        chk("lk4_r0_gnt", 32'(obs_g0), 32'd1);

        // Lock quota: r1 keeps asking for the lock, r0 gets in after LOCK_MAX grants.
        for (int i = 1; i <= 12; i++) begin
            step("quota", (i > 1), 0, 1, 8'h70, 8'(i), 1, 1, 1, 8'(8'h90 + i), 8'(i), 1'b0);
            if (i <= LOCK_MAX) chk("quota_r1_gnt", 32'(obs_g1), 32'd1);
            if (i == LOCK_MAX) chk("quota_busy_drop", 32'(ifc.busy), 32'd0);
            if (i == LOCK_MAX + 1) chk("quota_r0_wins", 32'(obs_g0), 32'd1);
        end
        idle("quota_end");

        // Reset in the middle of an r0 locked read burst with a read in flight.
        step("rl1", 1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1'b0);
        chk("rl1_busy", 32'(ifc.busy), 32'd1);
        step("rl2", 1, 1, 0, 8'h11, 8'h00, 1, 0, 1, 8'h12, 8'h00, 1'b1);
        chk("rl2_rvalid_dropped", 32'(ifc.r0_rvalid), 32'd0);

        // Idle: nothing requested for five cycles.
        for (int i = 0; i < 5; i++) begin
            idle("idle");
            chk("idle_mem_addr", 32'(ifc.mem_addr), 32'd0);
        end

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 49) == 0));
        end
        idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
